// File: rtl/regbank_wr_sched.sv
// ----------------------------------------------------------------------------
// regbank_wr_sched
//
// Write-port scheduler for a small register bank. Two write requesters
// (requester 0 = ALU, requester 1 = load unit) compete for the single bank
// write port. A round-robin priority bit chooses between them when both are
// valid. The accepted write is registered and presented to the bank one cycle
// later. A per-register busy scoreboard is set by instruction issue, cleared
// by an accepted write, and drives the decode stall.
//
// Register 0 is hard-wired: writes to it complete the handshake but never
// reach the bank, and it is never marked busy.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   wr0_valid/addr/data/ready requester 0 write handshake
//   wr1_valid/addr/data/ready requester 1 write handshake
//   iss_valid, iss_addr       issued instruction destination (sets busy)
//   rs1_addr, rs2_addr        decode source registers
//   stall                     a decode source register is busy
//   busy                      per-register pending-write vector
//   bank_wen/waddr/wdata      registered bank write port
// ----------------------------------------------------------------------------
module regbank_wr_sched #(
    parameter int AWIDTH = 3,
    parameter int DWIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr0_valid,
    input  logic [AWIDTH-1:0]      wr0_addr,
    input  logic [DWIDTH-1:0]      wr0_data,
    output logic                   wr0_ready,
    input  logic                   wr1_valid,
    input  logic [AWIDTH-1:0]      wr1_addr,
    input  logic [DWIDTH-1:0]      wr1_data,
    output logic                   wr1_ready,
    input  logic                   iss_valid,
    input  logic [AWIDTH-1:0]      iss_addr,
    input  logic [AWIDTH-1:0]      rs1_addr,
    input  logic [AWIDTH-1:0]      rs2_addr,
    output logic                   stall,
    output logic [2**AWIDTH-1:0]   busy,
    output logic                   bank_wen,
    output logic [AWIDTH-1:0]      bank_waddr,
    output logic [DWIDTH-1:0]      bank_wdata
);

    localparam int NREG = 2**AWIDTH;

    // prio = 0 prefers requester 0, prio = 1 prefers requester 1
    logic                prio;
    logic                gnt0_p0;
    logic                gnt1_p0;
    logic                vld_p0;
    logic [AWIDTH-1:0]   addr_p0;
    logic [DWIDTH-1:0]   data_p0;
    logic [NREG-1:0]     busy_r;
    logic [NREG-1:0]     busy_nxt;
    logic                wen_p1;
    logic [AWIDTH-1:0]   waddr_p1;
    logic [DWIDTH-1:0]   wdata_p1;

    // ---- stage p0: combinational arbitration and write select ----
    always_comb begin
        gnt0_p0 = 1'b0;
        gnt1_p0 = 1'b0;
        // Grants are suppressed during reset so no transfer is lost.
        if (!rst) begin
            if (wr0_valid && wr1_valid) begin
                gnt0_p0 = ~prio;
                gnt1_p0 = prio;
            end else begin
                gnt0_p0 = wr0_valid;
                gnt1_p0 = wr1_valid;
            end
        end
        vld_p0  = gnt0_p0 | gnt1_p0;
        addr_p0 = gnt1_p0 ? wr1_addr : wr0_addr;
        data_p0 = gnt1_p0 ? wr1_data : wr0_data;
    end

    // Scoreboard next state: clear first, then set, so a same-cycle set
    // of the same register wins. Register 0 is never busy.
    always_comb begin
        busy_nxt = busy_r;
        if (vld_p0) begin
            busy_nxt[addr_p0] = 1'b0;
        end
        if (iss_valid) begin
            busy_nxt[iss_addr] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    // ---- stage p1: registered bank write, priority and scoreboard ----
    always_ff @(posedge clk) begin
        if (rst) begin
            prio     <= 1'b0;
            busy_r   <= '0;
            wen_p1   <= 1'b0;
            waddr_p1 <= '0;
            wdata_p1 <= '0;
        end else begin
            // Toggle only on contention; a grant always exists out of reset.
            if (wr0_valid && wr1_valid) begin
                prio <= gnt0_p0;
            end
            busy_r <= busy_nxt;
            wen_p1 <= vld_p0 && (addr_p0 != '0);
            if (vld_p0) begin
                waddr_p1 <= addr_p0;
                wdata_p1 <= data_p0;
            end
        end
    end

    assign wr0_ready  = gnt0_p0;
    assign wr1_ready  = gnt1_p0;
    // Decode sees the current scoreboard only; no bypass of this cycle's write.
    assign stall      = busy_r[rs1_addr] | busy_r[rs2_addr];
    assign busy       = busy_r;
    assign bank_wen   = wen_p1;
    assign bank_waddr = waddr_p1;
    assign bank_wdata = wdata_p1;

endmodule

// File: doc/regbank_wr_sched.md
REGBANK_WR_SCHED -- requirements
Module: regbank_wr_sched

Interface
REQ-001 The block SHALL have parameter AWIDTH, default 3, register address width.
REQ-002 The block SHALL have parameter DWIDTH, default 8, register data width.
REQ-003 The block SHALL have these ports, one per line (name, direction, width, meaning):
- clk  input  1  clock; all state updates on posedge
- rst  input  1  synchronous active-high reset
- wr0_valid  input  1  requester 0 (ALU) write request
- wr0_addr  input  AWIDTH  requester 0 destination register
- wr0_data  input  DWIDTH  requester 0 write data
- wr0_ready  output  1  requester 0 request accepted this cycle
- wr1_valid  input  1  requester 1 (load unit) write request
- wr1_addr  input  AWIDTH  requester 1 destination register
- wr1_data  input  DWIDTH  requester 1 write data
- wr1_ready  output  1  requester 1 request accepted this cycle
- iss_valid  input  1  instruction issued with a destination register
- iss_addr  input  AWIDTH  destination register of issued instruction
- rs1_addr  input  AWIDTH  source register 1 of instruction in decode
- rs2_addr  input  AWIDTH  source register 2 of instruction in decode
- stall  output  1  decode source operand is pending
- busy  output  2**AWIDTH  per-register pending-write vector
- bank_wen  output  1  register bank write enable (registered)
- bank_waddr  output  AWIDTH  register bank write address (registered)
- bank_wdata  output  DWIDTH  register bank write data (registered)
REQ-004 The block SHALL use one clock; reset is synchronous and active-high.

Function
REQ-005 Arbitration SHALL be combinational: only one valid -> that requester granted; both valid -> requester selected by priority pointer prio granted; none -> no grant.
REQ-006 wrN_ready SHALL equal the grant for requester N; at most one ready high per cycle.
REQ-007 prio SHALL toggle to the non-granted requester only in cycles where both valid and a grant occurs; otherwise hold.
REQ-008 Requesters SHALL hold valid/addr/data stable until ready; an accepted transfer completes in the ready cycle.
REQ-009 On acceptance, bank_wen/bank_waddr/bank_wdata SHALL present the granted addr/data in the next cycle (latency 1); bank_wen SHALL be 0 in cycles following no acceptance.
REQ-010 An accepted write to address 0 SHALL complete handshake but produce bank_wen=0.
REQ-011 iss_valid with iss_addr!=0 SHALL set busy[iss_addr] on the next edge; iss_addr=0 ignored.
REQ-012 An accepted write SHALL clear busy[addr] on the next edge.
REQ-013 Set and clear of the same register in one cycle: set wins (busy stays 1).
REQ-014 busy[0] SHALL be constant 0.
REQ-015 stall SHALL be combinational: busy[rs1_addr] | busy[rs2_addr], from current busy (no bypass of same-cycle writes).
REQ-016 A write accepted for a register not busy SHALL still be performed; busy unchanged.

Reset
REQ-017 While rst=1 at a clock edge: busy=0, prio=0 (requester 0 preferred), bank_wen=0, bank_waddr=0, bank_wdata=0.
REQ-018 Reset mid-operation SHALL discard a registered pending write (bank_wen=0 next cycle) and all busy bits; combinational ready during rst SHALL be forced 0.

Verification
REQ-019 After reset, wr0 and wr1 both valid (addr 3/data 0x11, addr 5/data 0x22) held -> cycle1 wr0_ready=1, next cycle bank_wen=1 waddr=3 wdata=0x11; cycle2 wr1_ready=1, then waddr=5 wdata=0x22.
REQ-020 Both valid continuously for 6 cycles with new data each accept -> grants alternate 0,1,0,1,0,1.
REQ-021 iss_valid addr 4, then rs1_addr=4 -> stall=1; wr1 writes addr 4 -> busy[4]=0 next cycle, stall=0.
REQ-022 Same cycle iss_valid addr 2 and accepted write addr 2 -> busy[2]=1 afterwards.
REQ-023 wr0 write addr 0 data 0xFF -> wr0_ready=1, bank_wen=0 next cycle; iss_addr 0 -> busy[0]=0.
REQ-024 rst asserted the cycle after an accept -> bank_wen=0, busy all 0, prio=0.
